// File: rtl/rs_encoder_if.sv
// Byte-stream handshake bundle for the RS(204,188) encoder: message bytes in, code bytes out.
// master drives in_* and out_ready; slave is the encoder.
interface rs_encoder_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_sop;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_sop;
    logic       out_eop;
    logic       out_ready;

    modport master (
        output in_data, in_valid, in_sop, out_ready,
        input  in_ready, out_data, out_valid, out_sop, out_eop
    );

    modport slave (
        input  in_data, in_valid, in_sop, out_ready,
        output in_ready, out_data, out_valid, out_sop, out_eop
    );
endinterface

// File: rtl/rs_encoder.sv
// Systematic RS(K+16,K) encoder over GF(256)/0x11D, 16-stage LFSR; one registered output stage.
// Latency 1 cycle per byte; input stalls while parity drains or the output register is held.
// Optional mid-block resynchronisation on in_sop is enabled by defining RS_ENC_RESYNC_EN.
module rs_encoder #(
    parameter int K = 188
) (
    input  logic clk,
    input  logic reset,
    rs_encoder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;

    // Generator coefficients g_0..g_15; g_16 = 1 is implicit.
    localparam logic [7:0] G [16] = '{
        8'd59,  8'd36,  8'd50,  8'd98,  8'd229, 8'd41,  8'd65,  8'd163,
        8'd8,   8'd30,  8'd209, 8'd68,  8'd189, 8'd104, 8'd13,  8'd59
    };

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
        end
        return p;
    endfunction

    state_t     state;
    logic [7:0] byte_cnt;
    logic [3:0] par_cnt;
    logic [7:0] r     [16];
    logic [7:0] r_nxt [16];
    logic [7:0] fb;
    logic       out_free;
    logic       accept;
    logic       start;
    logic       last_msg;

    assign out_free     = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = (state != PARITY) && out_free;
    assign accept       = bus.in_valid && bus.in_ready;

`ifdef RS_ENC_RESYNC_EN
    assign start = accept && bus.in_sop;
`else
    assign start = accept && bus.in_sop && (state == IDLE);
`endif

    assign last_msg = start ? (K == 1) : (byte_cnt == 8'(K - 1));

    // A starting byte sees a cleared register, so the clear and the first update share one edge.
    always_comb begin
        fb       = bus.in_data ^ (start ? 8'h00 : r[15]);
        r_nxt[0] = gf_mul(G[0], fb);
        for (int i = 1; i < 16; i++) begin
            r_nxt[i] = (start ? 8'h00 : r[i-1]) ^ gf_mul(G[i], fb);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            byte_cnt      <= 8'd0;
            par_cnt       <= 4'd0;
            bus.out_valid <= 1'b0;
            bus.out_sop   <= 1'b0;
            bus.out_eop   <= 1'b0;
            bus.out_data  <= 8'h00;
            for (int i = 0; i < 16; i++) r[i] <= 8'h00;
        end else begin
            if (out_free) begin
                bus.out_valid <= 1'b0;
                bus.out_sop   <= 1'b0;
                bus.out_eop   <= 1'b0;
            end
            case (state)
                IDLE, DATA: begin
                    // Non-sop bytes accepted in IDLE fall through here and are dropped.
                    if (accept && (state == DATA || start)) begin
                        for (int i = 0; i < 16; i++) r[i] <= r_nxt[i];
                        bus.out_valid <= 1'b1;
                        bus.out_data  <= bus.in_data;
                        bus.out_sop   <= start;
                        bus.out_eop   <= 1'b0;
                        if (last_msg) begin
                            state    <= PARITY;
                            byte_cnt <= 8'd0;
                            par_cnt  <= 4'd0;
                        end else begin
                            state    <= DATA;
                            byte_cnt <= start ? 8'd1 : byte_cnt + 8'd1;
                        end
                    end
                end
                PARITY: begin
                    if (out_free) begin
                        bus.out_valid <= 1'b1;
                        bus.out_data  <= r[15];
                        bus.out_sop   <= 1'b0;
                        bus.out_eop   <= (par_cnt == 4'd15);
                        for (int i = 15; i > 0; i--) r[i] <= r[i-1];
                        r[0]    <= 8'h00;
                        par_cnt <= par_cnt + 4'd1;
                        // Leaving on the load of the last parity byte lets the next sop in while it drains.
                        if (par_cnt == 4'd15) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rs_encoder.sv
// Bench for rs_encoder: polynomial-division reference model, output scoreboard, syndrome check on every codeword.
module tb_rs_encoder;
    localparam int K = 188;
    localparam int N = K + 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    rs_encoder_if bus();
    rs_encoder #(.K(K)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

    typedef struct {
        logic [7:0] d;
        logic       s;
        logic       e;
        int         idx;
    } exp_t;

    exp_t       exp_q [$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] gp  [0:16];
    logic [7:0] msg [0:K-1];
    logic [7:0] cw  [0:N-1];
    logic [7:0] cap [0:N-1];
    int         cap_n = 0;
    int         cyc = 0;
    int         sop_cyc = 0;
    int         b2b = 0;
    bit         chk_bub = 0;
    bit         gaps = 0;
    bit         bp = 0;
    logic       stalled = 1'b0;
    logic [7:0] st_d = 8'h00;

    logic [7:0] g_lit [0:15] = '{8'd59, 8'd36, 8'd50, 8'd98, 8'd229, 8'd41, 8'd65, 8'd163,
                                 8'd8, 8'd30, 8'd209, 8'd68, 8'd189, 8'd104, 8'd13, 8'd59};
    logic [7:0] imp_lit [0:15] = '{8'h3B, 8'h0D, 8'h68, 8'hBD, 8'h44, 8'hD1, 8'h1E, 8'h08,
                                   8'hA3, 8'h41, 8'h29, 8'hE5, 8'h62, 8'h32, 8'h24, 8'h3B};

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
        end
        return p;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Codeword = message followed by the remainder of m(x)*x^16 divided by g(x).
    task automatic compute_cw();
        logic [7:0] w [0:N-1];
        logic [7:0] coef;
        for (int i = 0; i < N; i++) w[i] = (i < K) ? msg[i] : 8'h00;
        for (int i = 0; i < K; i++) begin
            coef = w[i];
            for (int j = 1; j <= 16; j++) w[i+j] = w[i+j] ^ gmul(coef, gp[16-j]);
        end
        for (int i = 0; i < N; i++) cw[i] = (i < K) ? msg[i] : w[i];
    endtask

    task automatic push_exp(input int nmsg, input bit par);
        exp_t e;
        for (int i = 0; i < nmsg; i++) begin
            e.d = cw[i]; e.s = (i == 0); e.e = 1'b0; e.idx = i;
            exp_q.push_back(e);
        end
        if (par) begin
            for (int i = K; i < N; i++) begin
                e.d = cw[i]; e.s = 1'b0; e.e = (i == N - 1); e.idx = i;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic rand_msg();
        for (int i = 0; i < K; i++) msg[i] = 8'($urandom_range(0, 255));
    endtask

    // Entered and left at posedge+1; returns once the byte has been accepted.
    task automatic drive_byte(input logic [7:0] d, input logic s);
        int n = 0;
        if (gaps && $urandom_range(0, 2) == 0) begin
            bus.in_valid = 1'b0;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_sop   = s;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            n++;
            if (n > 4000) begin
                check("accept_timeout", 32'(n), 32'd0);
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_sop   = 1'b0;
    endtask

    task automatic drive_msg(input int from, input int to, input int sop2);
        for (int i = from; i < to; i++) drive_byte(msg[i], (i == 0) || (i == sop2));
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            @(posedge clk); n++;
        end
        #1;
        check("drain", 32'(exp_q.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        cyc++;
        #1;
        bus.out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clk) begin : monitor
        exp_t       e;
        logic [7:0] a;
        logic [7:0] s;
        logic [7:0] syn_or;
        if (reset) begin
            stalled = 1'b0;
            cap_n   = 0;
        end else begin
            if (stalled && bus.out_valid) check("stall_hold", 32'(bus.out_data), 32'(st_d));
            stalled = bus.out_valid && !bus.out_ready;
            st_d    = bus.out_data;
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 32'(bus.out_data), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("out_byte[%0d] {sop,eop,data}", e.idx),
                          32'({bus.out_sop, bus.out_eop, bus.out_data}), 32'({e.s, e.e, e.d}));
                    if (e.idx >= K && e.idx < N - 1) check("in_ready_in_parity", 32'(bus.in_ready), 32'd0);
                end
                if (bus.out_sop) begin
                    cap_n   = 0;
                    sop_cyc = cyc;
                end
                if (cap_n < N) cap[cap_n] = bus.out_data;
                cap_n++;
                if (bus.out_eop) begin
                    check("codeword_len", 32'(cap_n), 32'(N));
                    if (cap_n == N) begin
                        syn_or = 8'h00;
                        a = 8'h01;
                        for (int i = 0; i < 16; i++) begin
                            s = 8'h00;
                            for (int k = 0; k < N; k++) s = gmul(s, a) ^ cap[k];
                            syn_or = syn_or | s;
                            a = gmul(a, 8'h02);
                        end
                        check("syndromes_or", 32'(syn_or), 32'd0);
                    end
                    if (chk_bub) check("no_bubbles", 32'(cyc - sop_cyc), 32'(N - 1));
                    if (bus.in_valid && bus.in_sop && bus.in_ready) b2b++;
                end
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] alpha;
        bus.in_valid  = 1'b0;
        bus.in_sop    = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b1;

        // Generator from its roots, pinned against the literal coefficient list.
        for (int d = 0; d <= 16; d++) gp[d] = 8'h00;
        gp[0] = 8'h01;
        alpha = 8'h01;
        for (int i = 0; i < 16; i++) begin
            for (int d = 16; d >= 1; d--) gp[d] = gp[d-1] ^ gmul(gp[d], alpha);
            gp[0] = gmul(gp[0], alpha);
            alpha = gmul(alpha, 8'h02);
        end
        for (int j = 0; j < 16; j++) check($sformatf("g_%0d", j), 32'(gp[j]), 32'(g_lit[j]));
        check("g_16", 32'(gp[16]), 32'd1);

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_sop", 32'(bus.out_sop), 32'd0);
        check("rst_out_eop", 32'(bus.out_eop), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;

        // All-zero block, continuous flow.
        chk_bub = 1;
        for (int i = 0; i < K; i++) msg[i] = 8'h00;
        compute_cw();
        push_exp(K, 1);
        drive_msg(0, K, -1);
        wait_drain();

        // Impulse in the last message byte: parity must equal the generator coefficients.
        msg[K-1] = 8'h01;
        compute_cw();
        for (int i = 0; i < 16; i++) check($sformatf("impulse_model_p%0d", i), 32'(cw[K+i]), 32'(imp_lit[i]));
        push_exp(K, 1);
        drive_msg(0, K, -1);
        wait_drain();

        // Three random blocks back to back.
        for (int b = 0; b < 3; b++) begin
            rand_msg();
            compute_cw();
            push_exp(K, 1);
            drive_msg(0, K, -1);
        end
        wait_drain();
        check("back_to_back_seen", 32'(b2b > 0), 32'd1);
        chk_bub = 0;

        // Backpressure and gapped input.
        bp = 1; gaps = 1;
        for (int b = 0; b < 2; b++) begin
            rand_msg();
            compute_cw();
            push_exp(K, 1);
            drive_msg(0, K, -1);
        end
        wait_drain();
        bp = 0; gaps = 0;

        // Reset at message byte 100.
        rand_msg();
        compute_cw();
        push_exp(K, 1);
        drive_msg(0, 100, -1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("post_reset_out_valid", 32'(bus.out_valid), 32'd0);
        @(posedge clk); #1;

        // Leading junk with in_sop=0 must be dropped, then a fresh block.
        for (int i = 0; i < 5; i++) drive_byte(8'($urandom_range(1, 255)), 1'b0);
        rand_msg();
        compute_cw();
        push_exp(K, 1);
        drive_msg(0, K, -1);
        wait_drain();

        // sop re-asserted at byte 50.
`ifdef RS_ENC_RESYNC_EN
        rand_msg();
        compute_cw();
        push_exp(50, 0);
        drive_msg(0, 50, -1);
        rand_msg();
        compute_cw();
        push_exp(K, 1);
        drive_msg(0, K, -1);
`else
        rand_msg();
        compute_cw();
        push_exp(K, 1);
        drive_msg(0, K, 50);
`endif
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
